// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl shared types and defaults.
// State encoding and default sizing for the counter sequencer.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } ctrl_state_t;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 300;

endpackage

// File: rtl/counter_ctrl_wdog.sv
// counter_ctrl_wdog: RUN-state cycle watchdog.
// Used only when COUNTER_CTRL_TIMEOUT_EN is defined.
module counter_ctrl_wdog #(
  parameter int LIMIT = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // expired marks the LIMIT-th counted cycle
  assign expired = (cnt == CW'(LIMIT - 1));

  // cycle count, cleared per operation, holds once expired
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: preloads an up-counter and runs it to a target.
// Optional RUN timeout: define COUNTER_CTRL_TIMEOUT_EN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_start,
  input  logic [DATA_WIDTH-1:0] cmd_target,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] count_in,
  output logic                  ld,
  output logic                  en,
  output logic [DATA_WIDTH-1:0] datain,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  ctrl_state_t           state;
  logic [DATA_WIDTH-1:0] start_q;
  logic [DATA_WIDTH-1:0] target_q;
  logic                  match;
  logic                  tmo;

  assign match     = (count_in == target_q);
  assign cmd_ready = (state == IDLE);
  assign datain    = start_q;

  // enable stops in the matching cycle so the counter halts on target
  assign en = (state == RUN) && !match && !abort;

`ifdef COUNTER_CTRL_TIMEOUT_EN
  counter_ctrl_wdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == LOAD),
    .inc    (state == RUN),
    .expired(tmo)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  // sequencer FSM with registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ld       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      start_q  <= '0;
      target_q <= '0;
    end else begin
      ld   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            start_q  <= cmd_start;
            target_q <= cmd_target;
            ld       <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (match) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (tmo) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: closes the loop with an 8-bit up-counter model.
// Build with COUNTER_CTRL_TIMEOUT_EN to exercise the watchdog.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_start = '0;
  logic [7:0] cmd_target = '0;
  logic       abort = 1'b0;
  logic [7:0] count_in;
  logic       ld, en, busy, done, err;
  logic [7:0] datain;

  logic [7:0] cnt = '0;
  logic       force0 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // loadable up-counter the controller drives
  always @(posedge clk) begin
    if (ld) cnt <= datain;
    else if (en) cnt <= cnt + 8'd1;
  end

  assign count_in = force0 ? 8'd0 : cnt;

  counter_ctrl #(
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(300)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_target(cmd_target),
    .abort     (abort),
    .count_in  (count_in),
    .ld        (ld),
    .en        (en),
    .datain    (datain),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] start;
    logic [7:0] target;
    int         en_cyc;
    int         run_cyc;
  } vec_t;

  vec_t vecs[5];

  int ldc, enc, runc, donec, errc, rdyc;
  logic [7:0] ldv;

  // observe one operation from LOAD to the cycle after DONE
  task automatic watch(input int limit);
    bit fin = 0;
    ldc = 0; enc = 0; runc = 0; donec = 0;
    errc = 0; rdyc = 0; ldv = '0;
    for (int i = 0; i < limit && !fin; i++) begin
      if (ld) begin ldc++; ldv = datain; end
      if (en) enc++;
      if (cmd_ready) rdyc++;
      if (busy && !ld && !done) runc++;
      if (err) errc++;
      if (done) begin donec++; fin = 1; end
      @(negedge clk);
    end
    if (!fin) chk("watch_timeout", 0, 1);
  endtask

  task automatic issue(input logic [7:0] s,
                       input logic [7:0] t);
    cmd_start = s;
    cmd_target = t;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'd5,   8'd20, 15,  16};
    vecs[1] = '{8'd250, 8'd4,  10,  11};
    vecs[2] = '{8'd9,   8'd9,  0,   1};
    vecs[3] = '{8'd255, 8'd0,  1,   2};
    vecs[4] = '{8'd0,   8'd255, 255, 256};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_en", en, 0);
    chk("rst_ld", ld, 0);
    chk("rst_datain", datain, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    // table-driven closed-loop runs
    foreach (vecs[k]) begin
      chk("v_ready_pre", cmd_ready, 1);
      issue(vecs[k].start, vecs[k].target);
      watch(400);
      chk("v_ld_count", ldc, 1);
      chk("v_ld_value", ldv, vecs[k].start);
      chk("v_en_cycles", enc, vecs[k].en_cyc);
      chk("v_run_cycles", runc, vecs[k].run_cyc);
      chk("v_done_count", donec, 1);
      chk("v_ready_busy", rdyc, 0);
      chk("v_final", cnt, vecs[k].target);
      chk("v_ready_post", cmd_ready, 1);
      chk("v_done_post", done, 0);
      chk("v_busy_post", busy, 0);
      chk("v_datain_hold", datain, vecs[k].start);
    end

    // abort in the third RUN cycle
    issue(8'd0, 8'd100);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("ab_en_before", en, 1);
    abort = 1'b1;
    #1;
    chk("ab_en_same", en, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_ready", cmd_ready, 1);
    chk("ab_count", cnt, 2);
    issue(8'd3, 8'd6);
    watch(20);
    chk("ab_next_done", donec, 1);
    chk("ab_next_final", cnt, 6);

    // abort with command in IDLE: accepted, then LOAD aborts
    cmd_start = 8'd40;
    cmd_target = 8'd41;
    cmd_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ia_ld", ld, 1);
    chk("ia_datain", datain, 40);
    chk("ia_en", en, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("ia_busy", busy, 0);
    chk("ia_done", done, 0);
    @(negedge clk);

    // command held during an operation
    cmd_start = 8'd1;
    cmd_target = 8'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_start = 8'd7;
    cmd_target = 8'd8;
    watch(20);
    chk("hold_ready", rdyc, 0);
    chk("hold_ld", ldc, 1);
    chk("hold_final", cnt, 3);
    chk("hold_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_ld2", ld, 1);
    chk("hold_datain2", datain, 7);
    watch(20);
    chk("hold_done2", donec, 1);
    chk("hold_final2", cnt, 8);

    // abort in the DONE cycle still shows done
    issue(8'd2, 8'd3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    chk("ad_done", done, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("ad_idle", cmd_ready, 1);

    // async reset mid-RUN
    issue(8'd0, 8'd100);
    @(negedge clk);
    @(negedge clk);
    chk("ar_en_before", en, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_en", en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_done", done, 0);

    // stalled counter
    force0 = 1'b1;
    issue(8'd0, 8'd50);
`ifdef COUNTER_CTRL_TIMEOUT_EN
    begin
      bit fin = 0;
      runc = 0; donec = 0; errc = 0;
      for (int i = 0; i < 400 && !fin; i++) begin
        if (busy && !ld) runc++;
        if (done) donec++;
        if (err) begin errc++; fin = 1; end
        @(negedge clk);
      end
      chk("to_err", errc, 1);
      chk("to_run", runc, 300);
      chk("to_done", donec, 0);
      chk("to_busy", busy, 0);
      chk("to_ready", cmd_ready, 1);
      chk("to_err_pulse", err, 0);
    end
`else
    errc = 0; donec = 0;
    for (int i = 0; i < 350; i++) begin
      if (err) errc++;
      if (done) donec++;
      @(negedge clk);
    end
    chk("nt_err", errc, 0);
    chk("nt_done", donec, 0);
    chk("nt_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("nt_abort", busy, 0);
    chk("nt_err_end", err, 0);
`endif
    force0 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Upstream sequencer for the loadable up-counter (ports clk/en/rst/ld/datain/dataout).
- Accepts a command (start value, target value) over a valid/ready handshake.
- Drives ld/datain to preload the counter, then holds en until the counter's dataout equals the target.
- Reports completion with a one-cycle done pulse.
- Sits between the command/register block and the counter; the counter's dataout feeds back into count_in.

Parameters:
DATA_WIDTH, 8, width of start/target/count values (must equal the counter's Data_Width)
TIMEOUT_CYCLES, 300, RUN-state cycle limit; used only when the optional feature is compiled in

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_start  input  DATA_WIDTH  value to preload
cmd_target  input  DATA_WIDTH  value at which counting stops
abort  input  1  cancel current operation
count_in  input  DATA_WIDTH  counter dataout feedback
ld  output  1  counter load strobe
en  output  1  counter enable
datain  output  DATA_WIDTH  counter load value
busy  output  1  high in LOAD/RUN/DONE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle timeout pulse (tied 0 without the optional feature)

Behaviour:
- Reset (rst=0, async): state=IDLE. Registered outputs cleared: ld=0, datain=0, busy=0, done=0, err=0, start_q=0, target_q=0. Combinational outputs at reset follow from IDLE: cmd_ready=1, en=0.
- States: IDLE, LOAD, RUN, DONE (enum).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, capture start_q/target_q and go to LOAD.
  - cmd_ready=0 in all other states; commands there are not accepted and not queued.
- LOAD (exactly 1 cycle):
  - ld=1, datain=start_q, en=0.
  - Next state is RUN; the counter holds start_q from the following cycle.
- RUN:
  - en = (count_in != target_q), combinational; ld=0.
  - When count_in == target_q, go to DONE; en is already 0 in that cycle, so the counter stops exactly at target.
  - Wrap-around is legal. The counter wraps 2^W-1 -> 0, so RUN lasts ((target-start) mod 2^W)+1 cycles. Example: start=250, target=4 -> 11 RUN cycles.
  - start == target: one RUN cycle, zero increments.
- DONE (1 cycle): done=1, en=0, then IDLE. cmd_ready rises on the following cycle.
- abort:
  - In LOAD or RUN: go to IDLE next cycle. en drops combinationally in the same cycle; no done pulse.
  - In LOAD, ld still asserts that cycle.
  - In IDLE/DONE: ignored. If abort arrives in the DONE cycle, done still pulses.
- Simultaneous cmd_valid and abort in IDLE: the command is accepted.
- datain holds the last loaded value between operations.
- Async reset mid-RUN: en=0 immediately, busy=0, no done.

Optional Feature:
Macro COUNTER_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter (width $clog2(TIMEOUT_CYCLES+1)) clears on LOAD and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES while still in RUN (counter stalled or disconnected), the FSM goes to IDLE, err pulses 1 cycle, and done is not asserted.
  - An abort in the same cycle takes priority; no err pulse.
- Undefined: no timeout logic; err tied 0; RUN waits indefinitely for a match or abort.

Decomposition:
- Package counter_ctrl_pkg holds:
  - the state enum typedef ctrl_state_t {IDLE, LOAD, RUN, DONE}
  - the default DATA_WIDTH localparam
  - the default TIMEOUT_CYCLES localparam
- Sub-module counter_ctrl_wdog (timeout counter with clr/inc/expired) is instantiated only under COUNTER_CTRL_TIMEOUT_EN; otherwise the block is a single module.

Test Plan (bench closes the loop with the counter, Data_Width=8):
1. Reset, then cmd start=5 target=20 -> ld pulses 1 cycle with datain=5; en high 15 cycles; counter stops at 20; done pulses once; cmd_ready returns.
2. start=250 target=4 -> counter wraps 255->0; 11 RUN cycles; final dataout=4; done=1.
3. start=target=9 -> one LOAD, one RUN with en=0; done pulses; counter stays at 9.
4. abort at 3rd RUN cycle of start=0 target=100 -> en=0 same cycle; no done; IDLE next cycle; a new command is accepted.
5. cmd_valid held high during RUN -> cmd_ready=0 and no recapture; the held command is accepted only after DONE.
6. (macro defined) TIMEOUT_CYCLES=300, count_in forced to 0 with target=50 -> err pulse after 300 RUN cycles; done never asserted; FSM returns to IDLE. (macro undefined) err stays 0 throughout.
